// File: rtl/dnn_batch_sched_if.sv
// Signal bundle between the batch scheduler and its host, the inference engine
// and the result consumer. master = scheduler side, slave = environment side.
interface dnn_batch_sched_if #(
   parameter int DATA_WIDTH = 9,
   parameter int IMG_W      = 8
);
   // host command / status
   logic                         cmd_start;
   logic [IMG_W-1:0]             cmd_count;
   logic                         busy;
   logic                         batch_done;
   logic                         err;
   // engine control and class-score scan
   logic [IMG_W-1:0]             img_sel;
   logic                         eng_reset;
   logic                         eng_start;
   logic                         eng_done;
   logic [3:0]                   eng_out_idx;
   logic signed [DATA_WIDTH-1:0] eng_out;
   // result stream
   logic                         res_valid;
   logic                         res_ready;
   logic [3:0]                   res_class;
   logic signed [DATA_WIDTH-1:0] res_score;
   logic [IMG_W-1:0]             res_img;

   modport master (
      input  cmd_start, cmd_count, eng_done, eng_out, res_ready,
      output busy, batch_done, err, img_sel, eng_reset, eng_start, eng_out_idx,
             res_valid, res_class, res_score, res_img
   );

   modport slave (
      output cmd_start, cmd_count, eng_done, eng_out, res_ready,
      input  busy, batch_done, err, img_sel, eng_reset, eng_start, eng_out_idx,
             res_valid, res_class, res_score, res_img
   );
endinterface

// File: rtl/dnn_batch_sched.sv
// Batch scheduler: runs the inference engine once per image, scans its class
// scores for the argmax and streams results. Optional WAIT_DONE watchdog: DNN_SCHED_TIMEOUT_EN.
module dnn_batch_sched #(
   parameter int DATA_WIDTH     = 9,
   parameter int NUM_CLASSES    = 10,
   parameter int IMG_W          = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   dnn_batch_sched_if.master bus
);
   localparam int IDX_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENG_RST,
      S_ENG_START,
      S_WAIT_DONE,
      S_SCAN,
      S_EMIT
   } state_e;

   state_e                       state_q, state_d;
   logic [IMG_W-1:0]             count_q, count_d;
   logic [IMG_W-1:0]             img_q, img_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [IDX_W-1:0]             best_idx_q, best_idx_d;
   logic signed [DATA_WIDTH-1:0] best_q, best_d;
   logic                         done_q, done_d;
   logic                         timeout;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         img_q      <= '0;
         idx_q      <= '0;
         best_idx_q <= '0;
         best_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         img_q      <= img_d;
         idx_q      <= idx_d;
         best_idx_q <= best_idx_d;
         best_q     <= best_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      img_d      = img_q;
      idx_d      = idx_q;
      best_idx_d = best_idx_q;
      best_d     = best_q;
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_start) begin
               if (bus.cmd_count != '0) begin
                  count_d = bus.cmd_count;
                  img_d   = '0;
                  state_d = S_ENG_RST;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_ENG_RST:   state_d = S_ENG_START;
         S_ENG_START: state_d = S_WAIT_DONE;
         S_WAIT_DONE: begin
            // a done arriving on the timeout cycle still counts as success
            if (bus.eng_done) begin
               idx_d   = '0;
               state_d = S_SCAN;
            end else if (timeout) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            // strictly-greater signed compare keeps the lowest index on ties
            if (idx_q == '0 || bus.eng_out > best_q) begin
               best_d     = bus.eng_out;
               best_idx_d = idx_q;
            end
            if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
               idx_d   = '0;
               state_d = S_EMIT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_EMIT: begin
            if (bus.res_ready) begin
               if (img_q == count_q - IMG_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  img_d   = img_q + IMG_W'(1);
                  state_d = S_ENG_RST;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef DNN_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;

   // tmo_q counts completed WAIT_DONE cycles of the current image
   assign timeout = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = '0;
      err_d = err_q;
      if (state_q == S_WAIT_DONE && !timeout)
         tmo_d = tmo_q + TMO_W'(1);
      if (state_q == S_IDLE && bus.cmd_start)
         err_d = 1'b0;
      else if (state_q == S_WAIT_DONE && !bus.eng_done && timeout)
         err_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.batch_done  = done_q;
   assign bus.img_sel     = img_q;
   assign bus.eng_reset   = (state_q == S_ENG_RST);
   assign bus.eng_start   = (state_q == S_ENG_START);
   assign bus.eng_out_idx = (state_q == S_SCAN) ? idx_q : '0;
   assign bus.res_valid   = (state_q == S_EMIT);
   assign bus.res_class   = best_idx_q;
   assign bus.res_score   = best_q;
   assign bus.res_img     = img_q;

   a_rst_then_start: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.eng_reset |=> bus.eng_start && !bus.eng_reset);

   a_start_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.eng_start |=> !bus.eng_start);

   a_payload_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.res_valid && !bus.res_ready |=>
         bus.res_valid && $stable({bus.res_class, bus.res_score, bus.res_img}));

   a_done_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.batch_done |-> !bus.busy);
endmodule

// File: tb/tb_dnn_batch_sched.sv
// Scoreboard bench for dnn_batch_sched: random score tables, argmax reference
// model, behavioural engine with configurable done latency, result monitor.
module tb_dnn_batch_sched;
   localparam int DW  = 9;
   localparam int NC  = 10;
   localparam int IW  = 8;
   localparam int TMO = 20;

   typedef struct {
      logic [3:0]         cls;
      logic signed [8:0]  score;
      logic [7:0]         img;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dnn_batch_sched_if #(.DATA_WIDTH(DW), .IMG_W(IW)) bus ();

   dnn_batch_sched #(
      .DATA_WIDTH(DW), .NUM_CLASSES(NC), .IMG_W(IW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   logic signed [8:0] scores [8][10];
   exp_t q[$];

   int lat_cfg = 0, lat_left = 0;
   int rst_pulses = 0, start_pulses = 0, done_pulses = 0;
   int exp_img = 0, s_cyc = 0, d_cyc = -100, last_rst = -100;
   int next_rst_exp = -1, exp_done_cyc = -1, cur_count = 0;
   int stall_img = -1, stall_left = 0, stall_seen = 0;
   bit rnd_ready = 1'b0;
   bit prev_valid = 1'b0, prev_stall = 1'b0;
   logic [20:0] saved_pl;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // engine scores are a pure table lookup on image and class index
   always_comb begin
      bus.eng_out = '0;
      if (bus.eng_out_idx < 4'd10)
         bus.eng_out = scores[bus.img_sel[2:0]][bus.eng_out_idx];
   end

   // behavioural engine: done rises lat_cfg cycles after eng_start, held until next eng_reset
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.eng_done = 1'b0;
         lat_left = 0;
      end else begin
         if (bus.eng_reset) begin
            rst_pulses++;
            chk("eng_reset_cycle", cyc, next_rst_exp);
            last_rst = cyc;
            bus.eng_done = 1'b0;
            lat_left = 0;
         end
         if (bus.eng_start) begin
            start_pulses++;
            chk("eng_start_after_reset", cyc, last_rst + 1);
            chk("img_sel_at_start", bus.img_sel, exp_img);
            exp_img++;
            s_cyc = cyc;
            lat_left = lat_cfg;
         end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) begin
               bus.eng_done = 1'b1;
               d_cyc = cyc;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bus.res_valid && stall_left > 0 && int'(bus.res_img) == stall_img) begin
         bus.res_ready = 1'b0;
         stall_left--;
      end else begin
         bus.res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // result monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.batch_done) begin
            done_pulses++;
            chk("batch_done_cycle", cyc, exp_done_cyc);
         end
         if (bus.res_valid && !prev_valid)
            chk("res_valid_latency", cyc, d_cyc + 11);
         if (prev_stall && bus.res_valid)
            chk("payload_stable", {bus.res_class, bus.res_score, bus.res_img}, saved_pl);
         if (bus.res_valid && bus.res_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got img %0d expected none", bus.res_img);
            end else begin
               e = q.pop_front();
               chk("res_class", bus.res_class, e.cls);
               chk("res_score", bus.res_score, e.score);
               chk("res_img", bus.res_img, e.img);
               if (int'(e.img) == cur_count - 1) exp_done_cyc = cyc + 1;
               else next_rst_exp = cyc + 1;
            end
         end
         prev_stall = bus.res_valid && !bus.res_ready;
         if (prev_stall && int'(bus.res_img) == stall_img) stall_seen++;
         saved_pl = {bus.res_class, bus.res_score, bus.res_img};
         prev_valid = bus.res_valid;
      end else begin
         prev_valid = 1'b0;
         prev_stall = 1'b0;
      end
   end

   // expected result: the maximum score, reported at its first occurrence
   function automatic exp_t ref_argmax(input int img);
      exp_t e;
      int mx = -100000;
      for (int k = 0; k < NC; k++) if (int'(scores[img][k]) > mx) mx = int'(scores[img][k]);
      e.cls = '0;
      for (int k = NC - 1; k >= 0; k--) if (int'(scores[img][k]) == mx) e.cls = 4'(k);
      e.score = 9'(mx);
      e.img = 8'(img);
      return e;
   endfunction

   task automatic fill(input int img, input int mode);
      int basic [10] = '{-3, 7, 2, 0, 1, -1, 4, 6, 5, 3};
      for (int k = 0; k < NC; k++) begin
         case (mode)
            1: scores[img][k] = 9'(basic[k]);
            2: scores[img][k] = (k == 3 || k == 7) ? 9'sd5 : 9'($urandom_range(0, 24) - 20);
            3: scores[img][k] = (k == 9) ? -9'sd1 : 9'(k - 256);
            4: scores[img][k] = 9'($urandom_range(0, 6) - 3);
            default: scores[img][k] = 9'($urandom_range(0, 511));
         endcase
      end
   endtask

   task automatic issue_cmd(input int count);
      @(posedge clk); #1;
      bus.cmd_start = 1'b1;
      bus.cmd_count = 8'(count);
      next_rst_exp = cyc + 1;
      exp_done_cyc = (count == 0) ? cyc + 1 : -1;
      exp_img = 0;
      cur_count = count;
      @(posedge clk); #1;
      bus.cmd_start = 1'b0;
      chk("err_clear_on_cmd", bus.err, 0);
   endtask

   task automatic wait_done_pulse(input int base, input string name);
      int t = 0;
      while (done_pulses == base && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (t >= 3000) begin
         checks++;
         errors++;
         $display("FAIL %s: got no batch_done expected one within 3000 cycles", name);
      end
   endtask

   task automatic run_batch(input int count, input int mode, input int lat, input bit poke);
      int b_rst = rst_pulses, b_start = start_pulses, b_done = done_pulses;
      for (int i = 0; i < count; i++) begin
         fill(i, mode);
         q.push_back(ref_argmax(i));
      end
      lat_cfg = lat;
      issue_cmd(count);
      if (poke) begin
         repeat (4) @(posedge clk);
         #1;
         chk("busy_in_wait", bus.busy, 1);
         bus.cmd_start = 1'b1;
         bus.cmd_count = 8'd5;
         @(posedge clk); #1;
         bus.cmd_start = 1'b0;
      end
      wait_done_pulse(b_done, "batch_timeout");
      repeat (3) @(posedge clk);
      #1;
      chk("eng_reset_pulses", rst_pulses - b_rst, count);
      chk("eng_start_pulses", start_pulses - b_start, count);
      chk("batch_done_pulses", done_pulses - b_done, 1);
      chk("busy_after_batch", bus.busy, 0);
      chk("results_left", q.size(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_start, b_done, t;
      bus.cmd_start = 1'b0;
      bus.cmd_count = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {bus.busy, bus.batch_done, bus.img_sel, bus.eng_reset, bus.eng_start,
                         bus.eng_out_idx, bus.res_valid, bus.err}, 0);
      chk("reset_payload", {bus.res_class, bus.res_score, bus.res_img}, 0);
      rst_n = 1'b1;

      run_batch(1, 1, 5, 1'b0);
      run_batch(1, 2, 3, 1'b0);
      run_batch(1, 3, 7, 1'b0);

      stall_img = 1; stall_left = 4; stall_seen = 0;
      run_batch(3, 0, 4, 1'b0);
      chk("stall_cycles", stall_seen, 4);
      stall_img = -1;

      run_batch(0, 0, 3, 1'b0);
      run_batch(2, 0, 30, 1'b1);

      rnd_ready = 1'b1;
      for (int n = 0; n < 6; n++)
         run_batch($urandom_range(1, 4), ($urandom_range(0, 1) != 0) ? 4 : 0, $urandom_range(1, 8), 1'b0);
      rnd_ready = 1'b0;

      // reset while the second image waits for an engine that never finishes
      for (int i = 0; i < 3; i++) fill(i, 0);
      q.push_back(ref_argmax(0));
      b_start = start_pulses;
      b_done = done_pulses;
      lat_cfg = 4;
      issue_cmd(3);
      t = 0;
      while (start_pulses == b_start && t < 200) begin @(posedge clk); t++; end
      lat_cfg = 0;
      while (start_pulses < b_start + 2 && t < 400) begin @(posedge clk); t++; end
      chk("second_image_started", start_pulses - b_start, 2);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_ctrl", {bus.busy, bus.batch_done, bus.img_sel, bus.eng_reset, bus.eng_start,
                                bus.eng_out_idx, bus.res_valid, bus.err}, 0);
      chk("midrun_reset_payload", {bus.res_class, bus.res_score, bus.res_img}, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_pulses - b_done, 0);
      chk("results_after_reset", q.size(), 0);

`ifdef DNN_SCHED_TIMEOUT_EN
      b_start = start_pulses;
      b_done = done_pulses;
      lat_cfg = 0;
      issue_cmd(2);
      t = 0;
      while (start_pulses == b_start && t < 200) begin @(posedge clk); t++; end
      #1;
      exp_done_cyc = s_cyc + TMO + 1;
      wait_done_pulse(b_done, "timeout_done");
      #1;
      chk("timeout_err", bus.err, 1);
      chk("timeout_starts", start_pulses - b_start, 1);
      chk("timeout_busy", bus.busy, 0);
      run_batch(1, 0, 3, 1'b0);
      chk("err_after_new_batch", bus.err, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dnn_batch_sched.md
Name: dnn_batch_sched

Overview:
- Batch inference scheduler for the 9-bit fixed-point sigmoid inference engine.
- On command, runs the engine once per image in a batch. For each image it:
  - resets the engine, pulses start, and waits for done;
  - scans the 10 class outputs through the engine's output-index mux;
  - computes the argmax (predicted digit);
  - returns the result over a valid/ready handshake.
- Sits between the host/test controller and the engine top; drives the image-select input of the image memory wrapper.

Parameters:
DATA_WIDTH, 9, width of signed engine output score
NUM_CLASSES, 10, number of class outputs scanned (index width 4)
IMG_W, 8, width of batch count and image index
TIMEOUT_CYCLES, 65535, max cycles in WAIT_DONE before abort (used only with optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
cmd_start  in  1  batch start request, sampled in IDLE only
cmd_count  in  IMG_W  number of images in batch, latched on accepted cmd_start
busy  out  1  high in every state except IDLE
batch_done  out  1  one-cycle pulse at batch end (normal or aborted)
img_sel  out  IMG_W  current image index to memory wrapper
eng_reset  out  1  engine reset pulse
eng_start  out  1  engine start pulse
eng_done  in  1  engine done level
eng_out_idx  out  4  class index into engine output mux
eng_out  in  DATA_WIDTH  signed score, combinational from eng_out_idx
res_valid  out  1  result valid
res_ready  in  1  result accepted by consumer
res_class  out  4  argmax class index
res_score  out  DATA_WIDTH  signed max score
res_img  out  IMG_W  image index of result
err  out  1  sticky timeout flag (0 unless feature enabled)

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; internal counters cleared. Mid-operation reset aborts silently: no batch_done, no result.
- States: IDLE, ENG_RST, ENG_START, WAIT_DONE, SCAN, EMIT.
- IDLE:
  - cmd_start=1 with cmd_count≠0 → latch count, img_sel=0, go ENG_RST.
  - cmd_start=1 with cmd_count=0 → batch_done pulses next cycle; stay IDLE; no engine activity.
  - cmd_start while busy → ignored.
- ENG_RST: eng_reset=1 for exactly one cycle → ENG_START.
- ENG_START: eng_start=1 for exactly one cycle → WAIT_DONE.
- WAIT_DONE: hold until eng_done=1 → SCAN with idx=0. eng_done high on entry (stale) is not possible, because the engine was reset two cycles earlier.
- SCAN: one class per cycle, eng_out_idx=idx, eng_out sampled same cycle.
  - idx=0: loads best=eng_out, best_idx=0.
  - Later idx: update only when eng_out > best (signed compare, strictly greater), so ties resolve to the lowest index.
  - After idx=NUM_CLASSES-1 → EMIT.
- EMIT:
  - res_valid=1; res_class/res_score/res_img held stable until res_valid&&res_ready.
  - On handshake, if img_sel==count-1 → batch_done pulse, res_valid=0, IDLE.
  - Otherwise → img_sel+1, ENG_RST.
- Timing: cmd_start sampled at cycle 0 → eng_reset at cycle 1, eng_start at cycle 2. With eng_done first high at cycle D, SCAN occupies D+1..D+10 and res_valid rises at D+11. Handshake at cycle H → next eng_reset at H+1.
- eng_out_idx: 0 outside SCAN.
- img_sel: changes only on EMIT handshake; stable for a whole image.

Optional Feature:
- Macro: DNN_SCHED_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without eng_done → err=1 (sticky), no result emitted, batch_done pulses, state=IDLE.
  - err is cleared on the next accepted cmd_start.
- Disabled: no counter; err tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Basic argmax: cmd_count=1; engine model raises done 5 cycles after eng_start; scores {-3,7,2,0,1,-1,4,6,5,3} → res_class=1, res_score=7, res_img=0; res_valid at D+11; batch_done one cycle after handshake.
- Tie: scores 5 at idx 3 and idx 7, all others below 5 → res_class=3, res_score=5.
- All negative: scores -256..-248 at idx 0..8, -1 at idx 9 → res_class=9, res_score=-1 (signed compare).
- Backpressure batch: cmd_count=3; res_ready low for 4 cycles on image 1 → payload stable while stalled; img_sel goes 0,1,2; exactly three eng_reset and three eng_start pulses; one batch_done.
- Zero count and ignore while busy:
  - cmd_count=0 → no eng_start, batch_done pulses once, busy stays 0.
  - cmd_start during WAIT_DONE → no effect.
- Reset and timeout:
  - rst low during WAIT_DONE → all outputs 0 immediately, no batch_done.
  - With DNN_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, eng_done never asserted → err=1 and batch_done pulse after 20 WAIT_DONE cycles; next accepted cmd_start clears err.
